uart_host: RTL and testbench
============================

# uart_host

Host-side master for the configuration UART link. Accepts a register read or write command on a valid/ready interface and serializes it as an 18-bit packet onto the chip's `posi` line. For reads, it also receives the 8-bit response frame on the chip's `piso` line and returns the data with error status. It is used in the FPGA test harness and in the testbench to drive the on-chip configuration register file.

## Interface
- `CLKS_PER_BIT`, 4, `clk` cycles per serial bit; must be even and ≥ 2.
- `TIMEOUT_CYCLES`, 256, maximum cycles to wait for a read-response start bit.

Ports:
- `clk` input 1: system clock; the single clock for the block.
- `reset` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: command accepted when `cmd_valid` and `cmd_ready` are both high.
- `cmd_wrb` input 1: 0 = write, 1 = read.
- `cmd_addr` input 8: register address.
- `cmd_data` input 8: write data; ignored for reads.
- `rsp_valid` output 1: one-cycle completion pulse, issued for both reads and writes.
- `rsp_data` output 8: read data; valid only while `rsp_valid` is high.
- `rsp_error` output 1: qualifies `rsp_valid`; set on read timeout, parity error or framing error.
- `busy` output 1: high whenever the block is not in IDLE.
- `posi` output 1: serial line to the chip; idles high.
- `piso` input 1: serial line from the chip; asynchronous, idles high.

## Operation
- Packet layout: bit 0 = wrb, bits 8:1 = data, bits 16:9 = addr, bit 17 = parity.
  - Parity is the XOR of bits 16:0, so the full 18-bit packet has even parity.
  - For reads, the data field is sent as 0x00.
- Transmit frame on `posi`: start bit (0), packet bits 0..17 LSB first, stop bit (1). That is 20 bits in total.
- Response frame on `piso`: start bit (0), data bits LSB first (8 bits), parity bit, stop bit (1).
  - Parity is even over the 8 data bits plus the parity bit.
- `piso` passes through a 2-flop synchronizer before any use.
- The command is captured into internal registers on acceptance; inputs may change afterwards.
- State machine:
  - IDLE: `cmd_ready`=1. On accept, go to TX.
  - TX: shift out the 20-bit frame, holding each bit for `CLKS_PER_BIT` cycles. After the stop bit, go to DONE for a write or WAIT_RSP for a read.
  - WAIT_RSP: watch the synchronized `piso` for a low level.
    - On low, go to RX_START.
    - If `TIMEOUT_CYCLES` cycles elapse first, go to DONE with a timeout error.
  - RX_START: wait `CLKS_PER_BIT/2` cycles, then re-check the line.
    - Still low: go to RX.
    - High: treat as a false start and return to WAIT_RSP. The timeout counter keeps running and does not restart.
  - RX: sample the line every `CLKS_PER_BIT` cycles, i.e. at mid-bit. Collect 8 data bits, then parity, then stop, then go to DONE.
  - DONE: pulse `rsp_valid` for one cycle, then return to IDLE.
- DONE outcomes:
  - Write: `rsp_data`=0x00, `rsp_error`=0.
  - Read success: `rsp_data` = received byte, `rsp_error`=0.
  - Parity mismatch or stop bit = 0: `rsp_error`=1, `rsp_data` = received byte.
  - Timeout: `rsp_error`=1, `rsp_data`=0x00.
- While `busy`, `cmd_ready` is low and `cmd_valid` has no effect.

## Timing
- Reset values: `posi`=1, `rsp_valid`=0, `rsp_data`=0x00, `rsp_error`=0, `busy`=0. `cmd_ready`=0 while `reset` is high and 1 in the first cycle after release.
- Reset asserted mid-operation: on the next edge the state is IDLE and `posi`=1, and no `rsp_valid` is issued.
- Transmit timing, with T = acceptance cycle:
  - `posi` drives the start bit during T+1..T+`CLKS_PER_BIT`.
  - Packet bit k occupies the following `CLKS_PER_BIT` cycles.
  - The stop bit ends at T+20·`CLKS_PER_BIT`.
- Write completion: `rsp_valid` is high at T+20·`CLKS_PER_BIT`+1. `cmd_ready` returns high on the cycle after that.
- WAIT_RSP begins at T+20·`CLKS_PER_BIT`+1. The timeout counter counts WAIT_RSP and RX_START cycles.
- Read completion: `rsp_valid` is 1 cycle after the stop-bit sample.
- Back-to-back commands: the minimum gap is 1 IDLE cycle.

## Test plan
- Write, `CLKS_PER_BIT`=4, addr 0x05, data 0xA3, wrb 0:
  - `posi` = 0, then bits 1,1,0,0,0,1,0,1 (data LSB first, following the wrb=0 bit), then addr 1,0,1,0,0,0,0,0, then parity 0, then stop 1, each held 4 cycles.
  - `rsp_valid` at T+81 with `rsp_error`=0.
- Read, addr 0x03: transmitted parity bit is 1. The chip model replies 0x5A with parity 0 and stop 1, starting 10 cycles after WAIT_RSP entry → `rsp_data`=0x5A, `rsp_error`=0.
- Read, response 0x5A with parity 1 → `rsp_valid` with `rsp_error`=1, `rsp_data`=0x5A. Stop bit 0 with correct parity gives the same result.
- Read, no response → `rsp_valid` with `rsp_error`=1, `rsp_data`=0x00, exactly 256 cycles after WAIT_RSP entry.
- False start: `piso` low for 1 cycle during WAIT_RSP, then a valid frame for 0xC3 → glitch ignored, `rsp_data`=0xC3, `rsp_error`=0.
- Reset raised at T+30 of a write → `posi`=1 and IDLE on the next edge, no `rsp_valid`. A new write is accepted on the first cycle after reset release.

Source files
------------

// File: rtl/uart_host_if.sv
// Command/response bus between a configuration client and uart_host.
// The client drives commands; uart_host answers with ready, completion and status.
interface uart_host_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_wrb;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_error;
   logic       busy;

   modport master (
      output cmd_valid, cmd_wrb, cmd_addr, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data, rsp_error, busy
   );

   modport slave (
      input  cmd_valid, cmd_wrb, cmd_addr, cmd_data,
      output cmd_ready, rsp_valid, rsp_data, rsp_error, busy
   );
endinterface

// File: rtl/uart_host.sv
// Host-side master for the configuration UART: serializes an 18-bit register
// command onto posi and, for reads, receives the 8-bit response frame on piso.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | ready for a command
// S_TX       | shifting start + 18-bit packet + stop onto posi
// S_WAIT_RSP | read: waiting for a response start bit, timeout running
// S_RX_START | start bit seen, confirming it at mid-bit
// S_RX       | sampling 8 data bits, parity and stop at mid-bit
// S_DONE     | rsp_valid pulse, then back to idle
module uart_host #(
   parameter int CLKS_PER_BIT   = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic       clk,
   input  logic       reset,
   uart_host_if.slave bus,
   output logic       posi,
   input  logic       piso
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX,
      S_WAIT_RSP,
      S_RX_START,
      S_RX,
      S_DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [4:0]        bits_left;
   logic [TO_W-1:0]   to_cnt;
   logic [18:0]       tx_sh;
   logic [8:0]        rx_sh;
   logic              is_read;
   logic              piso_s1;
   logic              piso_s2;
   logic [16:0]       pkt_body;
   logic              pkt_parity;

   always_comb begin
      pkt_body      = {bus.cmd_addr, (bus.cmd_wrb ? 8'h00 : bus.cmd_data), bus.cmd_wrb};
      pkt_parity    = ^pkt_body;
      bus.cmd_ready = (state == S_IDLE) && !reset;
      bus.busy      = (state != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         posi          <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= 8'h00;
         bus.rsp_error <= 1'b0;
         piso_s1       <= 1'b1;
         piso_s2       <= 1'b1;
         bit_cnt       <= '0;
         bits_left     <= '0;
         to_cnt        <= '0;
         tx_sh         <= '1;
         rx_sh         <= '0;
         is_read       <= 1'b0;
      end else begin
         piso_s1 <= piso;
         piso_s2 <= piso_s1;
         case (state)
            S_IDLE: begin
               bus.rsp_valid <= 1'b0;
               if (bus.cmd_valid) begin
                  is_read   <= bus.cmd_wrb;
                  tx_sh     <= {1'b1, pkt_parity, pkt_body};
                  posi      <= 1'b0;
                  bit_cnt   <= CNT_W'(CLKS_PER_BIT - 1);
                  bits_left <= 5'd19;
                  state     <= S_TX;
               end
            end
            S_TX: begin
               if (bit_cnt == '0) begin
                  bit_cnt <= CNT_W'(CLKS_PER_BIT - 1);
                  if (bits_left == 5'd0) begin
                     if (is_read) begin
                        to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
                        state  <= S_WAIT_RSP;
                     end else begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= 8'h00;
                        bus.rsp_error <= 1'b0;
                        state         <= S_DONE;
                     end
                  end else begin
                     // tx_sh[0] holds the next frame bit; the stop bit is last in
                     posi      <= tx_sh[0];
                     tx_sh     <= {1'b1, tx_sh[18:1]};
                     bits_left <= bits_left - 5'd1;
                  end
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            S_WAIT_RSP: begin
               if (to_cnt != '0) to_cnt <= to_cnt - 1'b1;
               if (!piso_s2) begin
                  bit_cnt <= CNT_W'(CLKS_PER_BIT / 2 - 1);
                  state   <= S_RX_START;
               end else if (to_cnt == '0) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_data  <= 8'h00;
                  bus.rsp_error <= 1'b1;
                  state         <= S_DONE;
               end
            end
            S_RX_START: begin
               // timeout keeps running across a false start
               if (to_cnt != '0) to_cnt <= to_cnt - 1'b1;
               if (bit_cnt == '0) begin
                  if (!piso_s2) begin
                     bit_cnt   <= CNT_W'(CLKS_PER_BIT - 1);
                     bits_left <= 5'd9;
                     state     <= S_RX;
                  end else begin
                     state <= S_WAIT_RSP;
                  end
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            S_RX: begin
               if (bit_cnt == '0) begin
                  bit_cnt <= CNT_W'(CLKS_PER_BIT - 1);
                  if (bits_left == 5'd0) begin
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_data  <= rx_sh[7:0];
                     bus.rsp_error <= (^rx_sh) | ~piso_s2;
                     state         <= S_DONE;
                  end else begin
                     rx_sh     <= {piso_s2, rx_sh[8:1]};
                     bits_left <= bits_left - 5'd1;
                  end
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            S_DONE: begin
               bus.rsp_valid <= 1'b0;
               bus.rsp_data  <= 8'h00;
               bus.rsp_error <= 1'b0;
               state         <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_host.sv
// Scoreboard bench for uart_host: directed spec cases plus random commands,
// with a behavioural chip model on piso and a frame checker on posi.
module tb_uart_host;
   localparam int CPB = 4;
   localparam int TO  = 256;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic piso  = 1'b1;
   logic posi;

   uart_host_if bus();

   uart_host #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .posi  (posi),
      .piso  (piso)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         at;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Expected 20-bit line image, index 0 first on the wire.
   function automatic logic [19:0] tx_frame(bit wrb, logic [7:0] addr, logic [7:0] data);
      logic [7:0]  d;
      logic [16:0] body;
      int          ones;
      d    = wrb ? 8'h00 : data;
      body = {addr, d, wrb};
      ones = $countones(body);
      return {1'b1, (ones % 2 == 1), body, 1'b0};
   endfunction

   // Caller is at a negedge. Returns at the negedge of T+80.
   task automatic send_cmd(bit wrb, logic [7:0] addr, logic [7:0] data,
                           logic [7:0] e_data, logic e_err, int off, output int t);
      logic [19:0] fr;
      exp_t        e;
      int          n;
      int          bad;
      logic        bad_val;
      fr  = tx_frame(wrb, addr, data);
      n   = 0;
      bad = -1;
      bad_val = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_wrb   = wrb;
      bus.cmd_addr  = addr;
      bus.cmd_data  = data;
      #1;
      while (!bus.cmd_ready && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 500) begin
         tests++;
         fails++;
         $display("FAIL cmd_accept: cmd_ready not seen within 500 cycles");
      end
      t = cyc;
      e.data = e_data;
      e.err  = e_err;
      e.at   = (off >= 0) ? t + off : -1;
      exp_q.push_back(e);
      for (int i = 0; i < 20 * CPB; i++) begin
         @(negedge clk);
         if (i == 0) begin
            bus.cmd_valid = 1'b0;
            bus.cmd_wrb   = 1'($urandom);
            bus.cmd_addr  = 8'($urandom);
            bus.cmd_data  = 8'($urandom);
         end
         if (bad < 0 && posi !== fr[i / CPB]) begin
            bad     = i;
            bad_val = posi;
         end
      end
      tests++;
      if (bad >= 0) begin
         fails++;
         $display("FAIL tx_frame addr=0x%0h at T+%0d: posi=%b, expected %b",
                  addr, bad + 1, bad_val, fr[bad / CPB]);
      end
   endtask

   // Chip side of a read: optional 1-cycle glitch, then a response frame.
   task automatic chip_reply(int delay, logic [7:0] d, bit par_flip, bit stop, bit glitch);
      logic [10:0] bits;
      if (glitch) begin
         repeat (3) @(negedge clk);
         piso = 1'b0;
         @(negedge clk);
         piso = 1'b1;
      end
      repeat (delay) @(negedge clk);
      bits = {stop, (^d) ^ par_flip, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         piso = bits[i];
         repeat (CPB) @(negedge clk);
      end
      piso = 1'b1;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         tests++;
         fails++;
         $display("FAIL rsp_wait: no rsp_valid within 1000 cycles, %0d pending", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   // Read with a chip reply; expected result derived from the frame rules.
   task automatic do_read(logic [7:0] addr, int kind, logic [7:0] d, int delay);
      int t;
      case (kind)
         0: send_cmd(1'b1, addr, 8'($urandom), 8'h00, 1'b1, 20 * CPB + 1 + TO, t);
         1: begin
            send_cmd(1'b1, addr, 8'($urandom), d, 1'b1, -1, t);
            chip_reply(delay, d, 1'b1, 1'b1, 1'b0);
         end
         2: begin
            send_cmd(1'b1, addr, 8'($urandom), d, 1'b1, -1, t);
            chip_reply(delay, d, 1'b0, 1'b0, 1'b0);
         end
         3: begin
            send_cmd(1'b1, addr, 8'($urandom), d, 1'b0, -1, t);
            chip_reply(delay + 4, d, 1'b0, 1'b1, 1'b1);
         end
         default: begin
            send_cmd(1'b1, addr, 8'($urandom), d, 1'b0, -1, t);
            chip_reply(delay, d, 1'b0, 1'b1, 1'b0);
         end
      endcase
      wait_done();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_rsp: rsp_valid with data 0x%0h err %b at cycle %0d",
                        bus.rsp_data, bus.rsp_error, cyc);
            end else begin
               e = exp_q.pop_front();
               check("rsp_data", bus.rsp_data, e.data);
               check("rsp_error", bus.rsp_error, e.err);
               if (e.at >= 0) check("rsp_cycle", cyc, e.at);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int t1;
      int t2;
      int rel;
      bus.cmd_valid = 1'b0;
      bus.cmd_wrb   = 1'b0;
      bus.cmd_addr  = 8'h00;
      bus.cmd_data  = 8'h00;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_posi", posi, 1);
      check("reset_rsp_valid", bus.rsp_valid, 0);
      check("reset_rsp_data", bus.rsp_data, 0);
      check("reset_rsp_error", bus.rsp_error, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_cmd_ready", bus.cmd_ready, 0);
      reset = 1'b0;
      #1;
      check("release_cmd_ready", bus.cmd_ready, 1);

      // write 0x05 <- 0xA3, completion at T+81
      send_cmd(1'b0, 8'h05, 8'hA3, 8'h00, 1'b0, 20 * CPB + 1, t1);
      wait_done();

      // back-to-back writes: one idle cycle between DONE and next accept
      send_cmd(1'b0, 8'h11, 8'h3C, 8'h00, 1'b0, 20 * CPB + 1, t1);
      send_cmd(1'b0, 8'hFE, 8'h81, 8'h00, 1'b0, 20 * CPB + 1, t2);
      check("b2b_gap", t2 - t1, 20 * CPB + 2);
      wait_done();

      do_read(8'h03, 4, 8'h5A, 10);
      do_read(8'h03, 1, 8'h5A, 10);
      do_read(8'h03, 2, 8'h5A, 10);
      do_read(8'h40, 0, 8'h00, 0);
      do_read(8'h7E, 3, 8'hC3, 6);

      // reset in the middle of a write
      bus.cmd_valid = 1'b1;
      bus.cmd_wrb   = 1'b0;
      bus.cmd_addr  = 8'h22;
      bus.cmd_data  = 8'h99;
      #1;
      t1 = cyc;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      while (cyc < t1 + 30) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_posi", posi, 1);
      check("midreset_busy", bus.busy, 0);
      check("midreset_cmd_ready", bus.cmd_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      rel = cyc;
      send_cmd(1'b0, 8'h23, 8'h45, 8'h00, 1'b0, 20 * CPB + 1, t2);
      check("post_reset_accept", t2, rel);
      wait_done();

      for (int k = 0; k < 10; k++) begin
         logic [7:0] a;
         logic [7:0] d;
         int         sc;
         a  = 8'($urandom);
         d  = 8'($urandom);
         sc = $urandom_range(0, 11);
         if ($urandom_range(0, 2) == 0) begin
            send_cmd(1'b0, a, d, 8'h00, 1'b0, 20 * CPB + 1, t1);
            wait_done();
         end else begin
            do_read(a, sc, d, $urandom_range(2, 40));
         end
      end

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
